reg_scan_checker: RTL and testbench

- Hardware run-and-verify controller for the processor/regfile system.
- Pulses a processor reset, then lets the CPU run for a programmed cycle count while logging every register write-back.
- Then takes over regfile read port A through the test-mode mux, scans r0..r31, and compares each value against an expected-value ROM.
- Reports per-register mismatches, an error count and pass/fail, so self-checking runs need no simulator file I/O.

---
 rtl/reg_scan_checker.sv | 159 +++++++++++++++
 tb/tb_reg_scan_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scan_checker.sv
// reg_scan_checker: run-and-verify controller for the processor/regfile system.
// It pulses the processor reset, lets the CPU run for N cycles while logging
// write-backs, then scans the regfile through read port A. Each register is
// compared against an expected-value ROM, and the block reports mismatches,
// an error count and pass/fail.
module reg_scan_checker #(
  parameter int NUM_REGS = 32,
  parameter int CYC_W    = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [CYC_W-1:0] i_num_cycles,
  output logic             o_cpu_reset,
  output logic             o_test_mode,
  output logic [4:0]       o_test_reg,
  input  logic [31:0]      i_reg_data,
  output logic [4:0]       o_exp_addr,
  input  logic [31:0]      i_exp_data,
  input  logic             i_wb_we,
  input  logic [4:0]       i_wb_rd,
  input  logic [31:0]      i_wb_data,
  output logic             o_log_valid,
  output logic [CYC_W-1:0] o_log_cycle,
  output logic [4:0]       o_log_rd,
  output logic [31:0]      o_log_data,
  output logic             o_mm_valid,
  output logic [4:0]       o_mm_reg,
  output logic [31:0]      o_mm_exp,
  output logic [31:0]      o_mm_act,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [5:0]       o_errors
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_CPU, S_RUN, S_SCAN, S_DRAIN, S_DONE
  } state_t;

  localparam logic [4:0]       IDX_LAST = 5'(NUM_REGS - 1);
  localparam logic [5:0]       ERR_MAX  = 6'(NUM_REGS);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

  state_t             r_state;
  logic [CYC_W-1:0]   r_n;
  logic [CYC_W-1:0]   r_cyc;
  logic [4:0]         r_idx;
  logic [4:0]         r_idx_q;
  logic [31:0]        r_act_q;
  logic               r_cmp_v;
  logic [5:0]         r_errors;
  logic               r_cpu_reset;
  logic               r_test_mode;
  logic               r_busy;
  logic               r_done;

  logic               w_run;
  logic               w_mm;

  // Compare stage: act_q/idx_q were captured one edge ago, exp_data arrives
  // from the synchronous ROM in the same cycle, so the two line up here.
  assign w_mm  = r_cmp_v && (r_act_q != i_exp_data);
  assign w_run = (r_state == S_RUN);

  // Controller FSM with registered control outputs, scan pipeline and error count
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_cyc       <= '0;
      r_idx       <= '0;
      r_idx_q     <= '0;
      r_act_q     <= '0;
      r_cmp_v     <= 1'b0;
      r_errors    <= '0;
      r_cpu_reset <= 1'b0;
      r_test_mode <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // A compare is pending in the cycle after every scan issue.
      r_cmp_v <= (r_state == S_SCAN);
      if (w_mm && r_errors != ERR_MAX)
        r_errors <= r_errors + 6'd1;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state     <= S_RST_CPU;
            r_n         <= i_num_cycles;
            r_errors    <= '0;
            r_cyc       <= '0;
            r_idx       <= '0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        S_RST_CPU: begin
          r_cpu_reset <= 1'b0;
          if (r_n != '0) begin
            r_state <= S_RUN;
          end else begin
            r_state     <= S_SCAN;
            r_test_mode <= 1'b1;
          end
        end
        S_RUN: begin
          r_cyc <= r_cyc + CYC_ONE;
          if (r_cyc == r_n - CYC_ONE) begin
            r_state     <= S_SCAN;
            r_test_mode <= 1'b1;
          end
        end
        S_SCAN: begin
          r_act_q <= i_reg_data;
          r_idx_q <= r_idx;
          if (r_idx == IDX_LAST) begin
            r_idx   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_idx <= r_idx + 5'd1;
          end
        end
        S_DRAIN: begin
          r_state     <= S_DONE;
          r_test_mode <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // r_idx sits at 0 outside SCAN, so it can drive both read addresses directly.
  assign o_test_reg  = r_idx;
  assign o_exp_addr  = r_idx;
  assign o_cpu_reset = r_cpu_reset;
  assign o_test_mode = r_test_mode;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_errors    = r_errors;
  assign o_pass      = r_done && (r_errors == '0);

  // Write-back log; r0 writes are architecturally dropped, so they are not logged.
  assign o_log_valid = w_run && i_wb_we && (i_wb_rd != 5'd0);
  assign o_log_cycle = o_log_valid ? r_cyc     : '0;
  assign o_log_rd    = o_log_valid ? i_wb_rd   : '0;
  assign o_log_data  = o_log_valid ? i_wb_data : '0;

  // Mismatch report, held at zero when no compare fails.
  assign o_mm_valid  = w_mm;
  assign o_mm_reg    = w_mm ? r_idx_q    : '0;
  assign o_mm_exp    = w_mm ? i_exp_data : '0;
  assign o_mm_act    = w_mm ? r_act_q    : '0;

endmodule

// File: tb/tb_reg_scan_checker.sv
// Bench for reg_scan_checker: models the regfile and the expected ROM, drives
// directed programs, and checks log/mismatch streams through scoreboard queues.
module tb_reg_scan_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_cycles = '0;
  logic        cpu_reset, test_mode;
  logic [4:0]  test_reg, exp_addr;
  logic [31:0] reg_data;
  logic [31:0] exp_data;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        log_valid;
  logic [7:0]  log_cycle;
  logic [4:0]  log_rd;
  logic [31:0] log_data;
  logic        mm_valid;
  logic [4:0]  mm_reg;
  logic [31:0] mm_exp, mm_act;
  logic        busy, done, pass;
  logic [5:0]  errors;

  reg_scan_checker #(.NUM_REGS(32), .CYC_W(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_num_cycles(num_cycles),
    .o_cpu_reset(cpu_reset), .o_test_mode(test_mode), .o_test_reg(test_reg),
    .i_reg_data(reg_data), .o_exp_addr(exp_addr), .i_exp_data(exp_data),
    .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .o_log_valid(log_valid), .o_log_cycle(log_cycle), .o_log_rd(log_rd),
    .o_log_data(log_data), .o_mm_valid(mm_valid), .o_mm_reg(mm_reg),
    .o_mm_exp(mm_exp), .o_mm_act(mm_act), .o_busy(busy), .o_done(done),
    .o_pass(pass), .o_errors(errors)
  );

  always #5 clk = ~clk;

  // Environment models: regfile (r0 hardwired zero) and synchronous ROM
  logic [31:0] regs [32];
  logic [31:0] rom  [32];
  assign reg_data = regs[test_reg];

  always @(posedge clk) begin
    exp_data <= rom[exp_addr];
    if (cpu_reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  typedef struct { int k; logic [4:0] rd; logic [31:0] d; } wr_t;
  typedef struct { logic [7:0] cyc; logic [4:0] rd; logic [31:0] d; } log_t;
  typedef struct { logic [4:0] rd; logic [31:0] e; logic [31:0] a; } mm_t;

  wr_t  wq[$];
  log_t lq[$];
  mm_t  mq[$];
  log_t le;
  mm_t  me;

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports an event
  always @(negedge clk) begin
    if (!rst) begin
      if (log_valid) begin
        if (lq.size() == 0) chk("log_unexpected", 32'd1, 32'd0);
        else begin
          le = lq.pop_front();
          chk("log_cycle", 32'(log_cycle), 32'(le.cyc));
          chk("log_rd",    32'(log_rd),    32'(le.rd));
          chk("log_data",  log_data,       le.d);
        end
      end
      if (mm_valid) begin
        if (mq.size() == 0) chk("mm_unexpected", 32'd1, 32'd0);
        else begin
          me = mq.pop_front();
          chk("mm_reg", 32'(mm_reg), 32'(me.rd));
          chk("mm_exp", mm_exp,      me.e);
          chk("mm_act", mm_act,      me.a);
        end
      end
    end
  end

  task automatic rom_fill(input logic [31:0] v);
    for (int i = 0; i < 32; i++) rom[i] = v;
  endtask

  // One complete run: push expectations, start, drive write-backs, time done
  task automatic do_run(input int n, input int mid_k, input int exp_err, input string tag);
    logic [31:0] er [32];
    mm_t m;
    log_t l;
    int e, k, crst, tm;
    for (int i = 0; i < 32; i++) er[i] = '0;
    foreach (wq[j]) if (wq[j].rd != 5'd0 && wq[j].k < n) er[wq[j].rd] = wq[j].d;
    for (int i = 0; i < 32; i++)
      if (rom[i] != er[i]) begin
        m.rd = 5'(i); m.e = rom[i]; m.a = er[i];
        mq.push_back(m);
      end
    start = 1'b1; num_cycles = 8'(n);
    @(posedge clk); #1;
    start = 1'b0; num_cycles = '0;
    chk({tag, "_cpu_reset_at_start"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_errors_cleared"}, 32'(errors), 32'd0);
    chk({tag, "_busy_at_start"}, 32'(busy), 32'd1);
    e = 0; crst = 1; tm = 0;
    forever begin
      k = e - 1;
      wb_we = 1'b0; wb_rd = '0; wb_data = '0;
      if (k >= 0 && k < n)
        foreach (wq[j])
          if (wq[j].k == k) begin
            wb_we = 1'b1; wb_rd = wq[j].rd; wb_data = wq[j].d;
            if (wq[j].rd != 5'd0) begin
              l.cyc = 8'(k); l.rd = wq[j].rd; l.d = wq[j].d;
              lq.push_back(l);
            end
          end
      if (k == mid_k) begin start = 1'b1; num_cycles = 8'd3; end
      else begin start = 1'b0; num_cycles = '0; end
      @(posedge clk); #1;
      e++;
      crst += int'(cpu_reset);
      tm += int'(test_mode);
      if (done) break;
      if (e > 400) begin chk({tag, "_done_timeout"}, 32'd0, 32'd1); break; end
    end
    wb_we = 1'b0; start = 1'b0;
    chk({tag, "_done_edge"}, 32'(e), 32'(n + 34));
    chk({tag, "_cpu_reset_cycles"}, 32'(crst), 32'd1);
    chk({tag, "_test_mode_cycles"}, 32'(tm), 32'd33);
    chk({tag, "_errors"}, 32'(errors), 32'(exp_err));
    chk({tag, "_pass"}, 32'(pass), (exp_err == 0) ? 32'd1 : 32'd0);
    chk({tag, "_log_left"}, 32'(lq.size()), 32'd0);
    chk({tag, "_mm_left"}, 32'(mq.size()), 32'd0);
    lq.delete(); mq.delete();
  endtask

  initial begin
    wr_t w;
    mm_t m;
    int sc;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    rom_fill(32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state_done", 32'(done), 32'd0);
    chk("rst_state_busy", 32'(busy), 32'd0);
    chk("rst_state_test_mode", 32'(test_mode), 32'd0);
    chk("rst_state_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("rst_state_errors", 32'(errors), 32'd0);
    chk("rst_state_pass", 32'(pass), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Program: r1=5, r2=-3, plus an r0 write that must not be logged
    w.k = 3;  w.rd = 5'd1; w.d = 32'd5;        wq.push_back(w);
    w.k = 7;  w.rd = 5'd2; w.d = 32'hFFFFFFFD; wq.push_back(w);
    w.k = 10; w.rd = 5'd0; w.d = 32'h55;       wq.push_back(w);
    rom[1] = 32'd5; rom[2] = 32'hFFFFFFFD;
    do_run(20, -100, 0, "clean");

    rom[2] = 32'd7;
    do_run(20, -100, 1, "rom_r2");

    rom[2] = 32'hFFFFFFFD;
    do_run(20, 5, 0, "start_in_run");

    wq.delete();
    rom_fill(32'd0);
    do_run(0, -100, 0, "n0");

    rom_fill(32'hFFFFFFFF);
    do_run(0, -100, 32, "all_ff");

    rom_fill(32'd0);
    do_run(0, -100, 0, "after_all_ff");

    // Abort mid-scan with one error already counted
    rom[1] = 32'd9;
    m.rd = 5'd1; m.e = 32'd9; m.a = 32'd0; mq.push_back(m);
    start = 1'b1; num_cycles = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    sc = 0;
    for (int c = 0; c < 200 && sc < 10; c++) begin
      @(posedge clk); #1;
      sc += int'(test_mode);
    end
    chk("abort_scan_reached", 32'(sc), 32'd10);
    chk("abort_errors_before", 32'(errors), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_test_mode_async", 32'(test_mode), 32'd0);
    chk("abort_busy_async", 32'(busy), 32'd0);
    chk("abort_errors", 32'(errors), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_mm_left", 32'(mq.size()), 32'd0);
    mq.delete(); lq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rom[1] = 32'd0;
    @(posedge clk); #1;
    do_run(4, -100, 0, "post_abort");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
